fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, the clock; rstd in 1, the reset (asynchronous, active-low).
REQ-002 SHALL have ports: start in 1 (leave IDLE/HALT); halt_req in 1 (request fetch halt); mem_busy in 1 (global freeze).
REQ-003 SHALL have ports: op_d, op_e, op_w in 6 each (opcodes in decode, execute, writeback); taken_w in 1 (control instr in W redirects; always 1 for jumps).
REQ-004 SHALL have ports: pc_hold out 1 (PC keeps value); pc_redirect out 1 (PC loads branch/jump target); bubble_f out 1 (F->D latch receives NOP).
REQ-005 SHALL have ports: kill_d, kill_e out 1 each (squash D/E to NOP); state out 3; stall_cnt, flush_cnt out 16 each.

Function
REQ-006 SHALL classify ctrl(op) = op in {32,33,34,35,40,41,42}; all other opcodes are non-control.
REQ-007 SHALL implement states IDLE=0, RUN=1, CTRL_WAIT=2, MEM_WAIT=3, HALT=4, all outputs driven combinationally from state and inputs.
REQ-008 IDLE: pc_hold=1, bubble_f=1; start=1 -> RUN next cycle.
REQ-009 Per-cycle priority SHALL be: mem_busy > halt_req > W redirect > D/E control stall > sequential advance.
REQ-010 mem_busy=1 in any non-IDLE state: pc_hold=1, all other outputs 0, go MEM_WAIT; prior state saved in a 3-bit register; mem_busy=0 returns to saved state in the following cycle.
REQ-011 A redirect SHALL NOT be lost under mem_busy: W is frozen by the pipeline, so resolution re-evaluates on exit.
REQ-012 RUN/CTRL_WAIT with halt_req=1 (mem_busy=0): HALT next cycle; HALT: pc_hold=1, bubble_f=1 until start=1 -> RUN.
REQ-013 ctrl(op_w)=1 and taken_w=1: pc_redirect=1, pc_hold=0 same cycle (zero added latency).
REQ-014 Stall mode: ctrl(op_d)|ctrl(op_e) -> pc_hold=1, bubble_f=1, state CTRL_WAIT; when both clear -> RUN; ctrl(op_w) in stall mode always gives pc_redirect=1 (not-taken target = held PC).
REQ-015 Simultaneous ctrl(op_w) and ctrl(op_d): redirect wins that cycle; D instruction is a bubble, so no stall results.
REQ-016 stall_cnt SHALL increment each cycle pc_hold=1 outside IDLE/HALT; flush_cnt SHALL increment each cycle kill_d|kill_e=1; both saturate at 16'hFFFF.

Reset
REQ-017 rstd=0 SHALL asynchronously force state=IDLE, saved state=IDLE, counters=0; outputs then pc_hold=1, bubble_f=1, all others 0.
REQ-018 Reset mid-stall or mid-halt SHALL discard all pending state; no redirect issued after release until a new ctrl op reaches W.

Configuration
REQ-019 Macro FETCH_PREDICT_NT_EN SHALL select static not-taken prediction.
REQ-020 Defined: no D/E control stall; CTRL_WAIT unreachable; taken redirect in W also drives kill_d=1, kill_e=1; not-taken (taken_w=0) gives no redirect, no kill.
REQ-021 Undefined: stall mode per REQ-014; kill_d, kill_e tied 0.

Structure
REQ-022 Shared package fetch_pkg SHALL hold opcode constants (OP_BEQ=32, OP_BNE=33, OP_BLT=34, OP_BLE=35, OP_J=40, OP_JAL=41, OP_JR=42), the state encoding and the ctrl() classifier function.
REQ-023 Sub-module sat_counter16 (enable, saturating) SHALL be instantiated twice for stall_cnt and flush_cnt.

Verification
REQ-024 Reset, start pulse, op_*=0 for 10 cycles -> state RUN, pc_hold=0, stall_cnt=0.
REQ-025 Stall mode: op_d=32 one cycle, then op_e=32, op_w=32 taken_w=1 -> pc_hold=1 two cycles, redirect third cycle, stall_cnt=2.
REQ-026 Predict mode: op_w=33 taken_w=1 -> pc_redirect=kill_d=kill_e=1 one cycle, flush_cnt=1; taken_w=0 -> no outputs.
REQ-027 mem_busy=1 three cycles during CTRL_WAIT -> MEM_WAIT, pc_hold=1, bubble_f=0; release -> CTRL_WAIT restored.
REQ-028 halt_req during RUN, start 5 cycles later -> HALT for 5 cycles, pc_hold=1, then RUN; stall_cnt unchanged.
REQ-029 rstd=0 asserted mid-CTRL_WAIT, stall_cnt forced to 16'hFFFE first -> immediate IDLE, counters 0; saturation separately checked at 16'hFFFF.

Source files
------------

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch controller: opcode constants for the
// control-transfer instructions, FSM state encoding, bus widths and the
// ctrl() classifier that tells whether an opcode redirects fetch.
// ----------------------------------------------------------------------------
package fetch_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned CNT_W   = 16;

   localparam logic [OP_W-1:0] OP_BEQ = OP_W'(32);
   localparam logic [OP_W-1:0] OP_BNE = OP_W'(33);
   localparam logic [OP_W-1:0] OP_BLT = OP_W'(34);
   localparam logic [OP_W-1:0] OP_BLE = OP_W'(35);
   localparam logic [OP_W-1:0] OP_J   = OP_W'(40);
   localparam logic [OP_W-1:0] OP_JAL = OP_W'(41);
   localparam logic [OP_W-1:0] OP_JR  = OP_W'(42);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_RUN       = 3'd1,
      ST_CTRL_WAIT = 3'd2,
      ST_MEM_WAIT  = 3'd3,
      ST_HALT      = 3'd4
   } state_t;

   // True for branches and jumps; everything else is sequential.
   function automatic logic ctrl(input logic [OP_W-1:0] op);
      logic r;
      r = 1'b0;
      case (op)
         OP_BEQ, OP_BNE, OP_BLT, OP_BLE,
         OP_J, OP_JAL, OP_JR: r = 1'b1;
         default:             r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter16.sv
// ----------------------------------------------------------------------------
// sat_counter16
// 16-bit event counter that increments on i_en and sticks at all-ones.
// Ports:
//   clk, rstd   clock, asynchronous active-low reset (clears the count)
//   i_en        count this cycle
//   o_count     current count value (registered)
// ----------------------------------------------------------------------------
module sat_counter16
   import fetch_pkg::*;
(
   input  logic             clk,
   input  logic             rstd,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // Count enabled events, holding at the maximum instead of wrapping.
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         r_count <= '0;
      end else if (i_en && (r_count != CNT_MAX)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
// Fetch-stage controller. Decides each cycle whether the PC holds, advances
// or loads a branch/jump target, and whether the F->D latch gets a bubble.
// Priority per cycle: mem_busy > halt_req > W redirect > D/E control stall
// > sequential advance. Control outputs are combinational from the state
// register and the inputs; the two counters are registered.
//
// Build option FETCH_PREDICT_NT_EN:
//   undefined - control ops in D/E stall fetch (CTRL_WAIT) until they reach
//               W, where every control op redirects (a not-taken target is
//               simply the held PC); kill_d/kill_e stay 0.
//   defined   - static not-taken prediction: no D/E stall, a taken op in W
//               redirects and squashes D and E; not-taken does nothing.
//
// Ports:
//   clk, rstd            clock, asynchronous active-low reset
//   start                leave IDLE/HALT
//   halt_req             request fetch halt
//   mem_busy             global freeze
//   op_d, op_e, op_w     opcodes in decode, execute, writeback
//   taken_w              control op in W is taken
//   pc_hold              PC keeps its value
//   pc_redirect          PC loads the branch/jump target
//   bubble_f             F->D latch receives a NOP
//   kill_d, kill_e       squash D / E to NOP
//   state                current FSM state
//   stall_cnt            cycles of PC hold while active (saturating)
//   flush_cnt            cycles with a squash (saturating)
// ----------------------------------------------------------------------------
module fetch_ctrl
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rstd,
   input  logic               start,
   input  logic               halt_req,
   input  logic               mem_busy,
   input  logic [OP_W-1:0]    op_d,
   input  logic [OP_W-1:0]    op_e,
   input  logic [OP_W-1:0]    op_w,
   input  logic               taken_w,
   output logic               pc_hold,
   output logic               pc_redirect,
   output logic               bubble_f,
   output logic               kill_d,
   output logic               kill_e,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   state_t r_state;
   state_t w_next_state;
   state_t r_saved;
   state_t w_next_saved;

   logic w_ctrl_d;
   logic w_ctrl_e;
   logic w_ctrl_w;
   logic w_redirect_req;
   logic w_stall_req;
   logic w_kill;
   logic w_unused;
   logic w_stall_en;
   logic w_flush_en;

   assign w_ctrl_d = ctrl(op_d);
   assign w_ctrl_e = ctrl(op_e);
   assign w_ctrl_w = ctrl(op_w);

`ifdef FETCH_PREDICT_NT_EN
   // Fetch runs ahead on the fall-through path; only a taken op costs a flush.
   assign w_redirect_req = w_ctrl_w & taken_w;
   assign w_stall_req    = 1'b0;
   assign w_kill         = 1'b1;
   assign w_unused       = w_ctrl_d ^ w_ctrl_e;
`else
   // Fetch waited behind the op, so the target is always valid to load.
   assign w_redirect_req = w_ctrl_w;
   assign w_stall_req    = w_ctrl_d | w_ctrl_e;
   assign w_kill         = 1'b0;
   assign w_unused       = taken_w;
`endif

   // State and saved-state registers.
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         r_state <= ST_IDLE;
         r_saved <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
         r_saved <= w_next_saved;
      end
   end

   // Next-state and output decode.
   always_comb begin
      w_next_state = r_state;
      w_next_saved = r_saved;
      pc_hold      = 1'b0;
      pc_redirect  = 1'b0;
      bubble_f     = 1'b0;
      kill_d       = 1'b0;
      kill_e       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            pc_hold  = 1'b1;
            bubble_f = 1'b1;
            if (start) begin
               w_next_state = ST_RUN;
            end
         end

         ST_HALT: begin
            if (mem_busy) begin
               pc_hold      = 1'b1;
               w_next_saved = r_state;
               w_next_state = ST_MEM_WAIT;
            end else begin
               pc_hold  = 1'b1;
               bubble_f = 1'b1;
               if (start) begin
                  w_next_state = ST_RUN;
               end
            end
         end

         // Frozen; W is frozen too, so the saved state re-resolves it on exit.
         ST_MEM_WAIT: begin
            pc_hold = 1'b1;
            if (!mem_busy) begin
               w_next_state = r_saved;
            end
         end

         ST_RUN, ST_CTRL_WAIT: begin
            if (mem_busy) begin
               pc_hold      = 1'b1;
               w_next_saved = r_state;
               w_next_state = ST_MEM_WAIT;
            end else if (halt_req) begin
               // Fetch stops from the next cycle on.
               w_next_state = ST_HALT;
            end else if (w_redirect_req) begin
               // A D-stage op behind the redirect is a bubble, so no stall.
               pc_redirect  = 1'b1;
               kill_d       = w_kill;
               kill_e       = w_kill;
               w_next_state = ST_RUN;
            end else if (w_stall_req) begin
               pc_hold      = 1'b1;
               bubble_f     = 1'b1;
               w_next_state = ST_CTRL_WAIT;
            end else begin
               w_next_state = ST_RUN;
            end
         end

         default: begin
            pc_hold      = 1'b1;
            bubble_f     = 1'b1;
            w_next_state = ST_IDLE;
         end
      endcase
   end

   assign state      = STATE_W'(r_state);
   assign w_stall_en = pc_hold && (r_state != ST_IDLE) && (r_state != ST_HALT);
   assign w_flush_en = kill_d | kill_e;

   sat_counter16 u_stall_cnt (
      .clk     (clk),
      .rstd    (rstd),
      .i_en    (w_stall_en),
      .o_count (stall_cnt)
   );

   sat_counter16 u_flush_cnt (
      .clk     (clk),
      .rstd    (rstd),
      .i_en    (w_flush_en),
      .o_count (flush_cnt)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. Inputs change 1 time unit after the rising
// edge; combinational outputs and counters are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_fetch_ctrl;

`ifdef FETCH_PREDICT_NT_EN
   localparam logic [15:0] HALT_STALL = 16'd0;
`else
   localparam logic [15:0] HALT_STALL = 16'd7;
`endif

   logic        clk;
   logic        rstd;
   logic        start;
   logic        halt_req;
   logic        mem_busy;
   logic [5:0]  op_d;
   logic [5:0]  op_e;
   logic [5:0]  op_w;
   logic        taken_w;
   logic        pc_hold;
   logic        pc_redirect;
   logic        bubble_f;
   logic        kill_d;
   logic        kill_e;
   logic [2:0]  state;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   int n_cmp;
   int n_err;

   fetch_ctrl dut (
      .clk         (clk),
      .rstd        (rstd),
      .start       (start),
      .halt_req    (halt_req),
      .mem_busy    (mem_busy),
      .op_d        (op_d),
      .op_e        (op_e),
      .op_w        (op_w),
      .taken_w     (taken_w),
      .pc_hold     (pc_hold),
      .pc_redirect (pc_redirect),
      .bubble_f    (bubble_f),
      .kill_d      (kill_d),
      .kill_e      (kill_e),
      .state       (state),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstd = 1'b0; start = 1'b0; halt_req = 1'b0; mem_busy = 1'b0;
      op_d = 6'd0; op_e = 6'd0; op_w = 6'd0; taken_w = 1'b0;
      #12;
      n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got=%0d want=0", state); end
      n_cmp++; if (pc_hold !== 1'b1) begin n_err++; $display("FAIL reset_pc_hold got=%b want=1", pc_hold); end
      n_cmp++; if (bubble_f !== 1'b1) begin n_err++; $display("FAIL reset_bubble_f got=%b want=1", bubble_f); end
      n_cmp++; if (pc_redirect !== 1'b0) begin n_err++; $display("FAIL reset_redirect got=%b want=0", pc_redirect); end
      n_cmp++; if ({kill_d, kill_e} !== 2'b00) begin n_err++; $display("FAIL reset_kill got=%b%b want=00", kill_d, kill_e); end
      n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt got=%0h want=0", stall_cnt); end
      n_cmp++; if (flush_cnt !== 16'd0) begin n_err++; $display("FAIL reset_flush_cnt got=%0h want=0", flush_cnt); end
      @(negedge clk);
      rstd = 1'b1;
   endtask

   task automatic test_start_run();
      tick();
      start = 1'b1;
      smp();
      n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL start_idle_state got=%0d want=0", state); end
      tick();
      start = 1'b0;
      repeat (10) tick();
      smp();
      n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL run_state got=%0d want=1", state); end
      n_cmp++; if (pc_hold !== 1'b0) begin n_err++; $display("FAIL run_pc_hold got=%b want=0", pc_hold); end
      n_cmp++; if (bubble_f !== 1'b0) begin n_err++; $display("FAIL run_bubble_f got=%b want=0", bubble_f); end
      n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL run_stall_cnt got=%0h want=0", stall_cnt); end
   endtask

   task automatic test_ctrl_stall();
      tick();
      op_d = 6'd32;
      smp();
      n_cmp++; if ({pc_hold, bubble_f, pc_redirect} !== 3'b110) begin n_err++; $display("FAIL stall_d_outs got=%b want=110", {pc_hold, bubble_f, pc_redirect}); end
      tick();
      op_d = 6'd0; op_e = 6'd32;
      smp();
      n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL stall_e_state got=%0d want=2", state); end
      n_cmp++; if (pc_hold !== 1'b1) begin n_err++; $display("FAIL stall_e_pc_hold got=%b want=1", pc_hold); end
      tick();
      op_e = 6'd0; op_w = 6'd32; taken_w = 1'b1;
      smp();
      n_cmp++; if ({pc_redirect, pc_hold} !== 2'b10) begin n_err++; $display("FAIL stall_w_redirect got=%b want=10", {pc_redirect, pc_hold}); end
      n_cmp++; if ({kill_d, kill_e} !== 2'b00) begin n_err++; $display("FAIL stall_w_kill got=%b want=00", {kill_d, kill_e}); end
      tick();
      op_w = 6'd0; taken_w = 1'b0;
      smp();
      n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL stall_done_state got=%0d want=1", state); end
      n_cmp++; if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL stall_cnt got=%0d want=2", stall_cnt); end
   endtask

   task automatic test_simul_w_d();
      tick();
      op_w = 6'd40; taken_w = 1'b1; op_d = 6'd33;
      smp();
      n_cmp++; if ({pc_redirect, pc_hold, bubble_f} !== 3'b100) begin n_err++; $display("FAIL wd_outs got=%b want=100", {pc_redirect, pc_hold, bubble_f}); end
      tick();
      op_w = 6'd34; taken_w = 1'b0; op_d = 6'd0;
      smp();
      n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL wd_state got=%0d want=1", state); end
      n_cmp++; if ({pc_redirect, pc_hold} !== 2'b10) begin n_err++; $display("FAIL nt_redirect got=%b want=10", {pc_redirect, pc_hold}); end
      tick();
      op_w = 6'd0;
      smp();
      n_cmp++; if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL wd_stall_cnt got=%0d want=2", stall_cnt); end
   endtask

   task automatic test_mem_busy();
      tick();
      op_d = 6'd32;
      smp();
      tick();
      op_d = 6'd0; op_e = 6'd32; mem_busy = 1'b1;
      smp();
      n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL mem_entry_state got=%0d want=2", state); end
      n_cmp++; if ({pc_hold, bubble_f, pc_redirect} !== 3'b100) begin n_err++; $display("FAIL mem_entry_outs got=%b want=100", {pc_hold, bubble_f, pc_redirect}); end
      tick();
      op_e = 6'd0; op_w = 6'd32; taken_w = 1'b1;
      smp();
      n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL mem_wait_state got=%0d want=3", state); end
      n_cmp++; if ({pc_hold, bubble_f, pc_redirect} !== 3'b100) begin n_err++; $display("FAIL mem_wait_outs got=%b want=100", {pc_hold, bubble_f, pc_redirect}); end
      tick();
      smp();
      tick();
      mem_busy = 1'b0;
      smp();
      n_cmp++; if ({state, pc_hold, pc_redirect} !== {3'd3, 2'b10}) begin n_err++; $display("FAIL mem_exit got=%0d/%b%b want=3/10", state, pc_hold, pc_redirect); end
      tick();
      smp();
      n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL mem_restore_state got=%0d want=2", state); end
      n_cmp++; if ({pc_redirect, pc_hold} !== 2'b10) begin n_err++; $display("FAIL mem_redirect_kept got=%b want=10", {pc_redirect, pc_hold}); end
      tick();
      op_w = 6'd0; taken_w = 1'b0;
      smp();
      n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL mem_run_state got=%0d want=1", state); end
      n_cmp++; if (stall_cnt !== 16'd7) begin n_err++; $display("FAIL mem_stall_cnt got=%0d want=7", stall_cnt); end
   endtask

   task automatic test_predict();
      tick();
      op_d = 6'd32;
      smp();
      n_cmp++; if ({pc_hold, bubble_f} !== 2'b00) begin n_err++; $display("FAIL pred_nostall got=%b want=00", {pc_hold, bubble_f}); end
      tick();
      op_d = 6'd0; op_w = 6'd33; taken_w = 1'b1;
      smp();
      n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL pred_state got=%0d want=1", state); end
      n_cmp++; if ({pc_redirect, kill_d, kill_e, pc_hold} !== 4'b1110) begin n_err++; $display("FAIL pred_taken got=%b want=1110", {pc_redirect, kill_d, kill_e, pc_hold}); end
      tick();
      taken_w = 1'b0;
      smp();
      n_cmp++; if ({pc_redirect, kill_d, kill_e} !== 3'b000) begin n_err++; $display("FAIL pred_nt got=%b want=000", {pc_redirect, kill_d, kill_e}); end
      n_cmp++; if (flush_cnt !== 16'd1) begin n_err++; $display("FAIL pred_flush_cnt got=%0d want=1", flush_cnt); end
      tick();
      op_w = 6'd0;
   endtask

   task automatic test_halt();
      tick();
      halt_req = 1'b1;
      smp();
      n_cmp++; if ({state, pc_hold} !== {3'd1, 1'b0}) begin n_err++; $display("FAIL halt_req_cycle got=%0d/%b want=1/0", state, pc_hold); end
      tick();
      halt_req = 1'b0;
      smp();
      n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL halt_state got=%0d want=4", state); end
      n_cmp++; if ({pc_hold, bubble_f} !== 2'b11) begin n_err++; $display("FAIL halt_outs got=%b want=11", {pc_hold, bubble_f}); end
      repeat (3) tick();
      tick();
      start = 1'b1;
      smp();
      n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL halt_5th_state got=%0d want=4", state); end
      tick();
      start = 1'b0;
      smp();
      n_cmp++; if ({state, pc_hold} !== {3'd1, 1'b0}) begin n_err++; $display("FAIL halt_resume got=%0d/%b want=1/0", state, pc_hold); end
      n_cmp++; if (stall_cnt !== HALT_STALL) begin n_err++; $display("FAIL halt_stall_cnt got=%0d want=%0d", stall_cnt, HALT_STALL); end
   endtask

   task automatic test_sat_reset();
      tick();
      op_d = 6'd32;
      repeat (65527) @(posedge clk);
      smp();
      n_cmp++; if (stall_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_fffe got=%0h want=fffe", stall_cnt); end
      n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL sat_state got=%0d want=2", state); end
      repeat (3) @(posedge clk);
      smp();
      n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_ffff got=%0h want=ffff", stall_cnt); end
      rstd = 1'b0;
      #1;
      n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL rst_mid_state got=%0d want=0", state); end
      n_cmp++; if ({stall_cnt, flush_cnt} !== 32'd0) begin n_err++; $display("FAIL rst_mid_cnt got=%0h/%0h want=0/0", stall_cnt, flush_cnt); end
      n_cmp++; if ({pc_hold, bubble_f, pc_redirect} !== 3'b110) begin n_err++; $display("FAIL rst_mid_outs got=%b want=110", {pc_hold, bubble_f, pc_redirect}); end
      op_d = 6'd0;
      @(negedge clk);
      rstd = 1'b1;
      tick();
      smp();
      n_cmp++; if ({state, pc_redirect} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL rst_release got=%0d/%b want=0/0", state, pc_redirect); end
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      smp();
      n_cmp++; if ({state, pc_redirect, pc_hold} !== {3'd1, 2'b00}) begin n_err++; $display("FAIL rst_restart got=%0d/%b%b want=1/00", state, pc_redirect, pc_hold); end
      n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_restart_cnt got=%0h want=0", stall_cnt); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_start_run();
`ifdef FETCH_PREDICT_NT_EN
      test_predict();
      test_halt();
`else
      test_ctrl_stall();
      test_simul_w_d();
      test_mem_busy();
      test_halt();
      test_sat_reset();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
